// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Detects load-use hazards against the EX slot and keeps saturating stall/bubble counters.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [4:0]       id_rs1_idx,
   input  logic [4:0]       id_rs2_idx,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_rd_idx,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [7:0]       id_ctrl,
   input  logic             flush,
   input  logic             hold,
   output logic             stall_if_id,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1_idx,
   output logic [4:0]       ex_rs2_idx,
   output logic [4:0]       ex_rd_idx,
   output logic [7:0]       ex_ctrl,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] bubble_count
);

   // id_ctrl / ex_ctrl packing: {regWrite, memRead, memWrite, memToReg, aluSrc, aluOp[2:0]}
   localparam int CTRL_MEM_READ = 6;

   logic rs1_match;
   logic rs2_match;
   logic load_use;
   logic load_bubble;

   assign rs1_match   = id_uses_rs1 && (id_rs1_idx == ex_rd_idx);
   assign rs2_match   = id_uses_rs2 && (id_rs2_idx == ex_rd_idx);
   assign load_use    = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd_idx != 5'd0) &&
                        id_valid && (rs1_match || rs2_match);
   assign stall_if_id = (load_use || hold) && !flush;

   // A flush overrides hold; a load-use bubble only enters when the stage is free to advance.
   assign load_bubble = flush || (!hold && load_use);

   always_ff @(posedge clk) begin
      if (rst || load_bubble) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1_idx  <= 5'd0;
         ex_rs2_idx  <= 5'd0;
         ex_rd_idx   <= 5'd0;
         ex_ctrl     <= 8'd0;
      end else if (!hold) begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1_idx  <= id_rs1_idx;
         ex_rs2_idx  <= id_rs2_idx;
         ex_rd_idx   <= id_rd_idx;
         ex_ctrl     <= id_valid ? id_ctrl : 8'd0;
      end
   end

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (load_use && !flush && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
         if (load_bubble && (bubble_count != {CNT_W{1'b1}}))
            bubble_count <= bubble_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage with a scoreboard queue and a decoupled monitor.
// Built with CNT_W=4 so counter saturation is reachable in a short run.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [7:0]      ctrl;
   } slot_t;

   typedef struct packed {
      logic             chk_stall;
      logic             stall;
      slot_t            slot;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] bc;
   } exp_t;

   localparam int EXP_W = $bits(exp_t);

   typedef struct {
      bit              rst, flush, hold, valid, u1, u2;
      logic [4:0]      rs1, rs2, rd;
      logic [XLEN-1:0] pc, d1, d2, imm;
      logic [7:0]      ctrl;
   } stim_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid = 1'b0;
   logic [XLEN-1:0]  id_pc = '0;
   logic [4:0]       id_rs1_idx = '0;
   logic [4:0]       id_rs2_idx = '0;
   logic             id_uses_rs1 = 1'b0;
   logic             id_uses_rs2 = 1'b0;
   logic [4:0]       id_rd_idx = '0;
   logic [XLEN-1:0]  id_rs1_data = '0;
   logic [XLEN-1:0]  id_rs2_data = '0;
   logic [XLEN-1:0]  id_imm = '0;
   logic [7:0]       id_ctrl = '0;
   logic             flush = 1'b0;
   logic             hold = 1'b0;
   logic             stall_if_id;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]       ex_rs1_idx, ex_rs2_idx, ex_rd_idx;
   logic [7:0]       ex_ctrl;
   logic [CNT_W-1:0] stall_count, bubble_count;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd_idx(id_rd_idx), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
      .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1_idx(ex_rs1_idx), .ex_rs2_idx(ex_rs2_idx), .ex_rd_idx(ex_rd_idx),
      .ex_ctrl(ex_ctrl), .stall_count(stall_count), .bubble_count(bubble_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // reference model: contents of the EX slot and the two counters
   slot_t m_slot = '0;
   int    m_sc = 0;
   int    m_bc = 0;
   bit    m_known = 1'b0;

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst   = ($urandom_range(0, 49) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.hold  = ($urandom_range(0, 7) == 0);
      s.valid = ($urandom_range(0, 5) != 0);
      s.u1    = $urandom_range(0, 1) == 1;
      s.u2    = $urandom_range(0, 1) == 1;
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.pc    = $urandom;
      s.d1    = $urandom;
      s.d2    = $urandom;
      s.imm   = $urandom;
      s.ctrl  = 8'($urandom);
      return s;
   endfunction

   function automatic stim_t quiet_stim();
      stim_t s;
      s = rand_stim();
      s.rst = 1'b0; s.flush = 1'b0; s.hold = 1'b0; s.valid = 1'b1;
      return s;
   endfunction

   // driver: apply one cycle of stimulus at the falling edge and push the expected response
   task automatic step(input stim_t s);
      exp_t  e;
      bit    lu;
      bit    bubble;
      id_valid = s.valid; id_pc = s.pc; id_rs1_idx = s.rs1; id_rs2_idx = s.rs2;
      id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_rd_idx = s.rd;
      id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm; id_ctrl = s.ctrl;
      rst = s.rst; flush = s.flush; hold = s.hold;

      // a load in EX blocks a dependent ID instruction, unless the load targets x0
      lu = m_slot.valid && m_slot.ctrl[6] && (m_slot.rd != 0) && s.valid &&
           ((s.u1 && s.rs1 == m_slot.rd) || (s.u2 && s.rs2 == m_slot.rd));
      e.chk_stall = m_known;
      e.stall     = (lu || s.hold) && !s.flush;

      if (s.rst) begin
         m_slot = '0; m_sc = 0; m_bc = 0; m_known = 1'b1;
      end else begin
         if (lu && !s.flush) m_sc = (m_sc == CMAX) ? CMAX : m_sc + 1;
         bubble = s.flush || (lu && !s.hold);
         if (bubble) begin
            m_slot = '0;
            m_bc = (m_bc == CMAX) ? CMAX : m_bc + 1;
         end else if (!s.hold) begin
            m_slot.valid = s.valid;
            m_slot.pc = s.pc; m_slot.d1 = s.d1; m_slot.d2 = s.d2; m_slot.imm = s.imm;
            m_slot.rs1 = s.rs1; m_slot.rs2 = s.rs2; m_slot.rd = s.rd;
            m_slot.ctrl = s.valid ? s.ctrl : 8'd0;
         end
      end
      e.slot = m_slot;
      e.sc   = CNT_W'(m_sc);
      e.bc   = CNT_W'(m_bc);
      exp_q.push_back(EXP_W'(e));
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // monitor: stall is checked mid-cycle, registered outputs just after the rising edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_t'(exp_q[0]);
            if (e.chk_stall) chk("stall_if_id", XLEN'(stall_if_id), XLEN'(e.stall));
            @(posedge clk);
            #1;
            e = exp_t'(exp_q.pop_front());
            chk("ex_valid", XLEN'(ex_valid), XLEN'(e.slot.valid));
            chk("ex_pc", ex_pc, e.slot.pc);
            chk("ex_rs1_data", ex_rs1_data, e.slot.d1);
            chk("ex_rs2_data", ex_rs2_data, e.slot.d2);
            chk("ex_imm", ex_imm, e.slot.imm);
            chk("ex_rs1_idx", XLEN'(ex_rs1_idx), XLEN'(e.slot.rs1));
            chk("ex_rs2_idx", XLEN'(ex_rs2_idx), XLEN'(e.slot.rs2));
            chk("ex_rd_idx", XLEN'(ex_rd_idx), XLEN'(e.slot.rd));
            chk("ex_ctrl", XLEN'(ex_ctrl), XLEN'(e.slot.ctrl));
            chk("stall_count", XLEN'(stall_count), XLEN'(e.sc));
            chk("bubble_count", XLEN'(bubble_count), XLEN'(e.bc));
         end
      end
   end

   initial begin
      stim_t s;
      int    budget;
      @(negedge clk);

      // reset with busy inputs, then an idle cycle
      for (int i = 0; i < 2; i++) begin
         s = quiet_stim(); s.rst = 1'b1; s.ctrl = 8'hD0; s.rd = 5'd5; step(s);
      end
      s = quiet_stim(); s.valid = 1'b0; step(s);

      // lw x5 then add x6,x5,x7: one stall, one bubble, then capture
      s = quiet_stim(); s.rd = 5'd5; s.ctrl = 8'hD0; step(s);
      s = quiet_stim(); s.rs1 = 5'd5; s.rs2 = 5'd7; s.rd = 5'd6; s.u1 = 1; s.u2 = 1; s.ctrl = 8'h80;
      step(s);
      step(s);

      // lw x0 never stalls; an unused matching rs2 never stalls
      s = quiet_stim(); s.rd = 5'd0; s.ctrl = 8'hD0; step(s);
      s = quiet_stim(); s.rs1 = 5'd0; s.u1 = 1; s.u2 = 0; step(s);
      s = quiet_stim(); s.rd = 5'd5; s.ctrl = 8'hD0; step(s);
      s = quiet_stim(); s.rs1 = 5'd1; s.rs2 = 5'd5; s.u1 = 1; s.u2 = 0; step(s);

      // flush wins over load-use
      s = quiet_stim(); s.rd = 5'd5; s.ctrl = 8'hD0; step(s);
      s = quiet_stim(); s.rs1 = 5'd5; s.u1 = 1; s.flush = 1; step(s);

      // hold for three cycles with changing ID fields, then release
      s = quiet_stim(); s.ctrl[6] = 1'b0; step(s);
      for (int i = 0; i < 3; i++) begin
         s = quiet_stim(); s.hold = 1; step(s);
      end
      s = quiet_stim(); step(s);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         s = rand_stim(); step(s);
      end

      // saturation: hold + load-use drives stall_count, flushes drive bubble_count
      s = quiet_stim(); s.rst = 1; step(s);
      s = quiet_stim(); s.rd = 5'd5; s.ctrl = 8'hD0; step(s);
      for (int i = 0; i < 20; i++) begin
         s = quiet_stim(); s.rs1 = 5'd5; s.u1 = 1; s.hold = 1; step(s);
      end
      for (int i = 0; i < 20; i++) begin
         s = quiet_stim(); s.flush = 1; step(s);
      end
      s = quiet_stim(); step(s);

      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
